// File: rtl/sync_fifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl_if
// Purpose : Groups the client request lines, the memory sequencing outputs and
//           the status/error flags of the synchronous FIFO controller.
// Signals :
//   wr_en, rd_en, clr_err      client -> controller requests
//   mem_w_en, mem_w_addr       controller -> memory write port
//   mem_r_addr                 controller -> memory show-head read port
//   full, empty, almost_full,
//   almost_empty, count        occupancy status (registered-state only)
//   overflow, underflow        sticky error flags
// Modports: master = client side, slave = controller side.
// -----------------------------------------------------------------------------
interface sync_fifo_ctrl_if #(
  parameter int DEPTH = 16
) ();
  localparam int AW = $clog2(DEPTH);

  logic          wr_en;
  logic          rd_en;
  logic          clr_err;
  logic          mem_w_en;
  logic [AW-1:0] mem_w_addr;
  logic [AW-1:0] mem_r_addr;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  modport master (
    output wr_en, rd_en, clr_err,
    input  mem_w_en, mem_w_addr, mem_r_addr,
    input  full, empty, almost_full, almost_empty, count,
    input  overflow, underflow
  );

  modport slave (
    input  wr_en, rd_en, clr_err,
    output mem_w_en, mem_w_addr, mem_r_addr,
    output full, empty, almost_full, almost_empty, count,
    output overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl
// Purpose : Sequences a dual-port memory (synchronous write port, combinational
//           show-head read port) as a single-clock FIFO. Owns the write/read
//           pointers, derives occupancy and status flags, and keeps sticky
//           overflow/underflow flags. Data never passes through this block.
// Ports   :
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   bus        sync_fifo_ctrl_if.slave: requests in, memory control and
//              status/error flags out
// Parameters:
//   DEPTH            entries, power of 2, >= 4
//   ALMOST_FULL_TH   almost_full  when count >= this (1..DEPTH)
//   ALMOST_EMPTY_TH  almost_empty when count <= this (0..DEPTH-1)
// -----------------------------------------------------------------------------
module sync_fifo_ctrl #(
  parameter int DEPTH           = 16,
  parameter int ALMOST_FULL_TH  = 14,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] AF_TH   = (AW+1)'(ALMOST_FULL_TH);
  localparam logic [AW:0] AE_TH   = (AW+1)'(ALMOST_EMPTY_TH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the addresses coincide.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;

  logic        full, empty;
  logic        wr_acc, rd_acc;
  logic        ovf_set, unf_set;
  logic [AW:0] count;

  // Status is derived from registered pointers only, so no request input
  // reaches a flag combinationally.
  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // Reset also masks the write strobe so the memory is never written while
  // the controller is being cleared.
  assign wr_acc = bus.wr_en & ~full & ~rst;
  assign rd_acc = bus.rd_en & ~empty;

  // A paired write+read at a boundary is a normal flow-through: the opposite
  // request proceeds, so only an unpaired request against a boundary is an
  // error.
  assign ovf_set = bus.wr_en & full  & ~bus.rd_en;
  assign unf_set = bus.rd_en & empty & ~bus.wr_en;

  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;

    // Set takes priority over clear when both occur in one cycle.
    if (bus.clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (ovf_set) overflow_d  = 1'b1;
    if (unf_set) underflow_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.mem_w_en     = wr_acc;
  assign bus.mem_w_addr   = wr_ptr_q[AW-1:0];
  assign bus.mem_r_addr   = rd_ptr_q[AW-1:0];
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.count        = count;
  assign bus.almost_full  = (count >= AF_TH);
  assign bus.almost_empty = (count <= AE_TH);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_ctrl
// Drives the controller with directed and random request patterns, keeps a
// queue-based FIFO reference model, and lets a separate monitor compare every
// cycle's outputs (and the memory head data) against expectations queued by
// the stimulus side. A small behavioural memory stands in for the dual-port
// RAM the controller sequences.
// -----------------------------------------------------------------------------
module tb_sync_fifo_ctrl;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int AF_TH = 14;
  localparam int AE_TH = 2;

  logic clk;
  logic rst;

  sync_fifo_ctrl_if #(.DEPTH(DEPTH)) bus ();

  sync_fifo_ctrl #(
    .DEPTH(DEPTH), .ALMOST_FULL_TH(AF_TH), .ALMOST_EMPTY_TH(AE_TH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Behavioural dual-port memory: synchronous write, combinational read.
  logic [7:0] mem [DEPTH];
  logic [7:0] w_data;
  logic [7:0] r_data;

  always @(posedge clk) if (bus.mem_w_en) mem[bus.mem_w_addr] <= w_data;
  assign r_data = mem[bus.mem_r_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checking
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------- reference model
  typedef struct {
    bit         w_en;
    int         w_addr;
    int         r_addr;
    int         count;
    bit         full;
    bit         empty;
    bit         af;
    bit         ae;
    bit         ovf;
    bit         unf;
    logic [7:0] head;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_q[$];
  int         wr_total;
  int         rd_total;
  bit         m_ovf;
  bit         m_unf;

  task automatic model_reset();
    model_q.delete();
    wr_total = 0;
    rd_total = 0;
    m_ovf    = 0;
    m_unf    = 0;
  endtask

  // One clock cycle of requests: expectation for this cycle is queued, then
  // the model advances to the post-edge state.
  task automatic step(input bit wr, input bit rd, input bit clr,
                      input logic [7:0] data);
    exp_t e;
    bit   m_full, m_empty, wacc, racc;
    @(negedge clk);
    bus.wr_en   = wr;
    bus.rd_en   = rd;
    bus.clr_err = clr;
    w_data      = data;

    m_full  = (model_q.size() == DEPTH);
    m_empty = (model_q.size() == 0);
    wacc    = wr && !m_full;
    racc    = rd && !m_empty;

    e.w_en   = wacc;
    e.w_addr = wr_total % DEPTH;
    e.r_addr = rd_total % DEPTH;
    e.count  = model_q.size();
    e.full   = m_full;
    e.empty  = m_empty;
    e.af     = (model_q.size() >= AF_TH);
    e.ae     = (model_q.size() <= AE_TH);
    e.ovf    = m_ovf;
    e.unf    = m_unf;
    e.head   = m_empty ? 8'h00 : model_q[0];
    exp_q.push_back(e);

    if (racc) begin
      void'(model_q.pop_front());
      rd_total++;
    end
    if (wacc) begin
      model_q.push_back(data);
      wr_total++;
    end
    if (clr) begin
      m_ovf = 0;
      m_unf = 0;
    end
    if (wr && m_full && !rd)  m_ovf = 1;
    if (rd && m_empty && !wr) m_unf = 1;
  endtask

  // ----------------------------------------------------------------- monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("mem_w_en",     32'(bus.mem_w_en),     32'(e.w_en));
        check("mem_w_addr",   32'(bus.mem_w_addr),   32'(e.w_addr));
        check("mem_r_addr",   32'(bus.mem_r_addr),   32'(e.r_addr));
        check("count",        32'(bus.count),        32'(e.count));
        check("full",         32'(bus.full),         32'(e.full));
        check("empty",        32'(bus.empty),        32'(e.empty));
        check("almost_full",  32'(bus.almost_full),  32'(e.af));
        check("almost_empty", 32'(bus.almost_empty), 32'(e.ae));
        check("overflow",     32'(bus.overflow),     32'(e.ovf));
        check("underflow",    32'(bus.underflow),    32'(e.unf));
        if (!e.empty) check("head_data", 32'(r_data), 32'(e.head));
      end
    end
  end

  // Direct check of the outputs that must hold while reset is asserted.
  task automatic check_reset_state();
    check("rst_count",        32'(bus.count),        32'd0);
    check("rst_empty",        32'(bus.empty),        32'd1);
    check("rst_full",         32'(bus.full),         32'd0);
    check("rst_almost_empty", 32'(bus.almost_empty), 32'd1);
    check("rst_almost_full",  32'(bus.almost_full),  32'd0);
    check("rst_overflow",     32'(bus.overflow),     32'd0);
    check("rst_underflow",    32'(bus.underflow),    32'd0);
    check("rst_mem_w_en",     32'(bus.mem_w_en),     32'd0);
    check("rst_mem_w_addr",   32'(bus.mem_w_addr),   32'd0);
    check("rst_mem_r_addr",   32'(bus.mem_r_addr),   32'd0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int pw, pr;
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
    w_data      = 8'h00;
    model_reset();
    #1;
    check_reset_state();
    @(negedge clk);
    rst = 1'b0;

    // Fill to full, then one write too many.
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 8'(i));
    step(1, 0, 0, 8'hEE);
    // Drain: head must present 0x00..0x0F in order.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h00);

    // Wrap-around: addresses run past DEPTH-1 back to 0.
    for (int i = 0; i < 10; i++) step(1, 0, 0, 8'(8'h40 + i));
    for (int i = 0; i < 10; i++) step(0, 1, 0, 8'h00);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 8'(8'h80 + i));

    // Simultaneous requests at full, at empty, and mid-occupancy.
    for (int i = 0; i < 6; i++) step(1, 0, 0, 8'(8'hA0 + i));
    step(1, 1, 0, 8'hBB);
    for (int i = 0; i < 15; i++) step(0, 1, 0, 8'h00);
    step(1, 1, 0, 8'hC0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 8'(8'hC1 + i));
    for (int i = 0; i < 20; i++) step(1, 1, 0, 8'(8'hD0 + i));
    for (int i = 0; i < 7; i++) step(0, 1, 0, 8'h00);

    // Underflow set, clear, and set-wins-over-clear.
    step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h00);
    step(0, 1, 0, 8'h00);
    step(0, 1, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    // Asynchronous reset mid-stream at count 5 with a write pending.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'hF0 + i));
    step(0, 0, 0, 8'h00);
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check_reset_state();
    @(negedge clk);
    bus.wr_en = 1'b0;
    rst       = 1'b0;
    model_reset();

    // Random traffic with varying write/read bias to sweep all occupancies.
    for (int blk = 0; blk < 8; blk++) begin
      pw = (blk % 2 == 0) ? 75 : 30;
      pr = (blk % 2 == 0) ? 30 : 75;
      for (int i = 0; i < 200; i++)
        step($urandom_range(99) < pw, $urandom_range(99) < pr,
             $urandom_range(99) < 5, 8'($urandom));
    end

    step(0, 0, 0, 8'h00);
    @(negedge clk);
    #4;
    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
